// File: rtl/keypad_matrix_emu_if.sv
// Request/status and column/row pin bundle between a press source and the keypad emulator.
interface keypad_matrix_emu_if;
  logic [2:0]  col;
  logic [3:0]  row;
  logic        req_valid;
  logic [3:0]  req_code;
  logic [15:0] req_hold_ms;
  logic        req_ready;
  logic        busy;
  logic        press_done;
  logic        code_err;

  modport master (
    output col, req_valid, req_code, req_hold_ms,
    input  row, req_ready, busy, press_done, code_err
  );

  modport slave (
    input  col, req_valid, req_code, req_hold_ms,
    output row, req_ready, busy, press_done, code_err
  );
endinterface

// File: rtl/keypad_matrix_emu.sv
// 12-key matrix emulator: one queued press (code, hold ticks) answers scanner column strobes on the rows.
// Row lags col by one cycle; req_ready only in IDLE; contact bounce optional via KEYEMU_BOUNCE_EN.
module keypad_matrix_emu #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int TICK_HZ   = 1000,
  parameter int GAP_MS    = 20
`ifdef KEYEMU_BOUNCE_EN
  , parameter int BOUNCE_MS = 5
`endif
) (
  input  logic               i_clock,
  input  logic               i_reset,
  keypad_matrix_emu_if.slave io_bus
);

  localparam int DIV = (CLK_FREQ / TICK_HZ < 1) ? 1 : CLK_FREQ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS,
    S_GAP
`ifdef KEYEMU_BOUNCE_EN
    , S_BOUNCE_IN,
    S_BOUNCE_OUT
`endif
  } state_t;

  state_t      r_state;
  logic [PW-1:0] r_presc;
  logic [15:0] r_cnt;
  logic [15:0] r_hold;
  logic [1:0]  r_r;
  logic [1:0]  r_c;
  logic [3:0]  r_row;
  logic        r_ready;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic        w_tick;
  logic [16:0] w_cnt_inc;
  logic [15:0] w_cnt_sat;
  logic        w_hold_done;
  logic        w_gap_done;
  logic        w_closed;
  logic        w_col_hit;
  logic [1:0]  w_dec_r;
  logic [1:0]  w_dec_c;
  logic        w_dec_ok;
  logic        w_accept;

  assign w_tick      = (r_presc == PW'(DIV - 1));
  assign w_cnt_inc   = {1'b0, r_cnt} + 17'd1;
  assign w_cnt_sat   = (r_cnt == 16'hFFFF) ? r_cnt : w_cnt_inc[15:0];
  assign w_hold_done = w_tick && (w_cnt_inc >= {1'b0, r_hold});
  assign w_gap_done  = w_tick && (w_cnt_inc >= 17'(GAP_MS));
  assign w_accept    = (r_state == S_IDLE) && r_ready && io_bus.req_valid;
  assign w_col_hit   = (r_c == 2'd0) ? io_bus.col[0] :
                       (r_c == 2'd1) ? io_bus.col[1] : io_bus.col[2];

`ifdef KEYEMU_BOUNCE_EN
  logic [15:0] r_lfsr;
  logic        w_bounce_done;

  assign w_bounce_done = w_tick && (w_cnt_inc >= 17'(BOUNCE_MS));
  // Contact chatters only in the bounce windows; PRESS is a solid closure.
  assign w_closed = (r_state == S_PRESS) ||
                    (((r_state == S_BOUNCE_IN) || (r_state == S_BOUNCE_OUT)) && r_lfsr[0]);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    end
  end
`else
  assign w_closed = (r_state == S_PRESS);
`endif

  // code = 3*r + c
  always_comb begin
    w_dec_r  = 2'd0;
    w_dec_c  = 2'd0;
    w_dec_ok = 1'b1;
    case (io_bus.req_code)
      4'd0:  begin w_dec_r = 2'd0; w_dec_c = 2'd0; end
      4'd1:  begin w_dec_r = 2'd0; w_dec_c = 2'd1; end
      4'd2:  begin w_dec_r = 2'd0; w_dec_c = 2'd2; end
      4'd3:  begin w_dec_r = 2'd1; w_dec_c = 2'd0; end
      4'd4:  begin w_dec_r = 2'd1; w_dec_c = 2'd1; end
      4'd5:  begin w_dec_r = 2'd1; w_dec_c = 2'd2; end
      4'd6:  begin w_dec_r = 2'd2; w_dec_c = 2'd0; end
      4'd7:  begin w_dec_r = 2'd2; w_dec_c = 2'd1; end
      4'd8:  begin w_dec_r = 2'd2; w_dec_c = 2'd2; end
      4'd9:  begin w_dec_r = 2'd3; w_dec_c = 2'd0; end
      4'd10: begin w_dec_r = 2'd3; w_dec_c = 2'd1; end
      4'd11: begin w_dec_r = 2'd3; w_dec_c = 2'd2; end
      default: w_dec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hold  <= 16'd1;
      r_r     <= '0;
      r_c     <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_tick) begin
        r_cnt <= w_cnt_sat;
      end
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_cnt <= '0;
            if (w_dec_ok) begin
              r_r     <= w_dec_r;
              r_c     <= w_dec_c;
              r_hold  <= (io_bus.req_hold_ms == 16'd0) ? 16'd1 : io_bus.req_hold_ms;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
`ifdef KEYEMU_BOUNCE_EN
              r_state <= S_BOUNCE_IN;
`else
              r_state <= S_PRESS;
`endif
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_PRESS: begin
          if (w_hold_done) begin
            r_cnt   <= '0;
`ifdef KEYEMU_BOUNCE_EN
            r_state <= S_BOUNCE_OUT;
`else
            r_state <= S_GAP;
`endif
          end
        end
        S_GAP: begin
          if (w_gap_done) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
`ifdef KEYEMU_BOUNCE_EN
        S_BOUNCE_IN: begin
          if (w_bounce_done) begin
            r_cnt   <= '0;
            r_state <= S_PRESS;
          end
        end
        S_BOUNCE_OUT: begin
          if (w_bounce_done) begin
            r_cnt   <= '0;
            r_state <= S_GAP;
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_row <= '0;
    end else if (w_closed && w_col_hit) begin
      r_row <= 4'b0001 << r_r;
    end else begin
      r_row <= '0;
    end
  end

  assign io_bus.row        = r_row;
  assign io_bus.req_ready  = r_ready;
  assign io_bus.busy       = r_busy;
  assign io_bus.press_done = r_done;
  assign io_bus.code_err   = r_err;

endmodule

// File: tb/tb_keypad_matrix_emu.sv
// Bench for keypad_matrix_emu at one tick per clock: directed table, corner sequences, random run vs press-window model.
module tb_keypad_matrix_emu;
  localparam int GAP = 20;

  logic clk = 1'b0;
  logic rst;
  keypad_matrix_emu_if kp ();

  keypad_matrix_emu #(.CLK_FREQ(1000), .TICK_HZ(1000), .GAP_MS(GAP)) dut (
    .i_clock(clk),
    .i_reset(rst),
    .io_bus (kp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  code;
    logic [15:0] hold;
    logic [2:0]  col;
    logic [3:0]  row;
    logic        err;
  } vec_t;

  vec_t tbl [9];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Model: the last accepted press closes the key for edges [a, a+h) and is done at a+h+GAP.
  bit   m_act = 1'b0;
  bit   m_rdy = 1'b0;
  int   m_a = 0, m_h = 1, m_r = 0, m_c = 0;
  int   acc_edge = 0, done_edge = -1, done_cnt = 0;
  logic [3:0] e_row;
  bit   e_rdy, e_busy, e_done, e_err;

  task automatic chk(input string nm, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, got, exp);
  endtask

  task automatic step();
    int e;
    e = cyc + 1;
    if (rst) begin
      e_row = 4'd0; e_rdy = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
      m_act = 1'b0;
    end else begin
      e_row = 4'd0;
      if (m_act && (e - 1 >= m_a) && (e - 1 < m_a + m_h) && kp.col[m_c])
        e_row = 4'(1 << m_r);
      e_done = m_act && (e == m_a + m_h + GAP);
      e_err  = 1'b0;
      if (m_rdy && kp.req_valid) begin
        if (kp.req_code < 12) begin
          m_act = 1'b1;
          m_a   = e;
          m_h   = (kp.req_hold_ms == 16'd0) ? 1 : int'(kp.req_hold_ms);
          m_r   = int'(kp.req_code) / 3;
          m_c   = int'(kp.req_code) % 3;
          acc_edge = e;
        end else begin
          e_err = 1'b1;
        end
      end
      e_busy = m_act && (e >= m_a) && (e < m_a + m_h + GAP);
      e_rdy  = !e_busy;
    end
    m_rdy = e_rdy;
    @(posedge clk);
    cyc = e;
    #1;
    chk("row", int'(kp.row), int'(e_row));
    chk("req_ready", int'(kp.req_ready), int'(e_rdy));
    chk("busy", int'(kp.busy), int'(e_busy));
    chk("press_done", int'(kp.press_done), int'(e_done));
    chk("code_err", int'(kp.code_err), int'(e_err));
    if (kp.press_done) begin
      done_edge = cyc;
      done_cnt++;
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100 && !kp.req_ready; i++) step();
    chk("ready_timeout", int'(kp.req_ready), 1);
  endtask

  initial begin
    int hits;
    int d_edge;
    int rise;
    bit prev_busy;

    tbl[0] = '{4'd11, 16'd2, 3'b111, 4'b1000, 1'b0};
    tbl[1] = '{4'd11, 16'd2, 3'b011, 4'b0000, 1'b0};
    tbl[2] = '{4'd0,  16'd1, 3'b001, 4'b0001, 1'b0};
    tbl[3] = '{4'd5,  16'd1, 3'b100, 4'b0010, 1'b0};
    tbl[4] = '{4'd7,  16'd0, 3'b010, 4'b0100, 1'b0};
    tbl[5] = '{4'd9,  16'd2, 3'b001, 4'b1000, 1'b0};
    tbl[6] = '{4'd13, 16'd3, 3'b111, 4'b0000, 1'b1};
    tbl[7] = '{4'd15, 16'd1, 3'b111, 4'b0000, 1'b1};
    tbl[8] = '{4'd6,  16'd1, 3'b110, 4'b0000, 1'b0};

    rst = 1'b1;
    kp.col = 3'b000; kp.req_valid = 1'b0; kp.req_code = 4'd0; kp.req_hold_ms = 16'd0;
    step();
    step();
    chk("reset_ready", int'(kp.req_ready), 0);
    rst = 1'b0;
    step();
    chk("ready_after_reset", int'(kp.req_ready), 1);

    // T1: code 4, hold 3, columns scanned round-robin
    kp.req_valid = 1'b1; kp.req_code = 4'd4; kp.req_hold_ms = 16'd3;
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      kp.col = 3'(1 << (i % 3));
      step();
      kp.req_valid = 1'b0;
      if (kp.row == 4'b0010) hits++;
    end
    chk("t1_row_hits", hits, 1);
    chk("t1_done_latency", done_edge - acc_edge, 3 + GAP);

    for (int k = 0; k < 9; k++) begin
      wait_ready();
      kp.col = tbl[k].col; kp.req_code = tbl[k].code; kp.req_hold_ms = tbl[k].hold;
      kp.req_valid = 1'b1;
      step();
      kp.req_valid = 1'b0;
      chk("tbl_err", int'(kp.code_err), int'(tbl[k].err));
      step();
      chk("tbl_row", int'(kp.row), int'(tbl[k].row));
    end

    // T4: hold 0 behaves as 1; a request held through the press is taken on the first IDLE cycle
    wait_ready();
    kp.col = 3'b100; kp.req_code = 4'd2; kp.req_hold_ms = 16'd0; kp.req_valid = 1'b1;
    step();
    d_edge = -1; rise = -1; prev_busy = kp.busy;
    for (int i = 0; i < 60; i++) begin
      step();
      if (kp.press_done && d_edge < 0) begin
        d_edge = cyc;
        chk("t4_hold0_latency", done_edge - acc_edge, 1 + GAP);
      end
      if (kp.busy && !prev_busy && rise < 0) rise = cyc;
      prev_busy = kp.busy;
    end
    chk("t4_reaccept_gap", rise - d_edge, 1);
    kp.req_valid = 1'b0;
    wait_ready();

    // T5: reset mid-press drops the press silently
    kp.col = 3'b111; kp.req_code = 4'd8; kp.req_hold_ms = 16'd50; kp.req_valid = 1'b1;
    step();
    kp.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("t5_row_before", int'(kp.row), 4);
    rst = 1'b1;
    step();
    chk("t5_row_reset", int'(kp.row), 0);
    rst = 1'b0;
    d_edge = done_cnt;
    for (int i = 0; i < 80; i++) step();
    chk("t5_no_done", done_cnt - d_edge, 0);

    for (int i = 0; i < 2500; i++) begin
      kp.col         = 3'($urandom_range(0, 7));
      kp.req_valid   = ($urandom_range(0, 3) == 0);
      kp.req_code    = 4'($urandom_range(0, 15));
      kp.req_hold_ms = 16'($urandom_range(0, 6));
      rst            = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    kp.req_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
